alu_fifo_param: RTL and testbench

ALU_FIFO_PARAM -- requirements
Module: alu_fifo_param

---
 rtl/alu_fifo_pkg.sv | 29 ++
 rtl/fifo_core.sv | 102 ++++++++++
 rtl/alu_fifo_param.sv | 91 +++++++++
 tb/tb_alu_fifo_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_fifo_pkg
//  Brief    : Shared defaults, status bundle and count-width helper for the
//             instruction/result FIFO pair.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_fifo_pkg;

    localparam int c_def_inst_w     = 32;
    localparam int c_def_inst_depth = 8;
    localparam int c_def_res_w      = 32;
    localparam int c_def_res_depth  = 16;
    localparam int c_def_af_margin  = 2;

    typedef struct packed {
        logic wr_ack;
        logic wr_err;
        logic rd_ack;
        logic rd_err;
    } fifo_status_t;

    // One extra bit so a completely full FIFO (count == DEPTH) is representable.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_core.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_core
//  Brief    : Single-clock FIFO channel with registered read data, per-request
//             ack/err pulses, synchronous flush and count-decoded flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_core
    import alu_fifo_pkg::*;
#(
    parameter int W         = c_def_inst_w,
    parameter int DEPTH     = c_def_inst_depth,
    parameter int AF_MARGIN = c_def_af_margin
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      wr_ack,
    output logic                      wr_err,
    output logic                      rd_ack,
    output logic                      rd_err,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [count_w(DEPTH)-1:0] count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = count_w(DEPTH);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [W-1:0]    r_dout;
    fifo_status_t    r_status;

    logic            w_rd_ok;
    logic            w_wr_ok;
    logic [31:0]     w_free;

    // A full FIFO still takes a write when a read frees a slot on the same edge;
    // an empty FIFO never forwards write data straight to dout.
    assign w_rd_ok = rd_en && (r_count != '0);
    assign w_wr_ok = wr_en && ((r_count != c_depth) || rd_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_status <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= '0;
        end else begin
            r_status.wr_ack <= w_wr_ok;
            r_status.wr_err <= wr_en && !w_wr_ok;
            r_status.rd_ack <= w_rd_ok;
            r_status.rd_err <= rd_en && !w_rd_ok;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign w_free      = 32'(DEPTH) - 32'(r_count);
    assign full        = (r_count == c_depth);
    assign empty       = (r_count == '0);
    assign almost_full = (w_free <= 32'(AF_MARGIN));
    assign count       = r_count;
    assign dout        = r_dout;
    assign wr_ack      = r_status.wr_ack;
    assign wr_err      = r_status.wr_err;
    assign rd_ack      = r_status.rd_ack;
    assign rd_err      = r_status.rd_err;

endmodule
`default_nettype wire

// File: rtl/alu_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : alu_fifo_param
//  Brief    : Independent instruction and result FIFO channels for the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_fifo_param
    import alu_fifo_pkg::*;
#(
    parameter int INST_W     = c_def_inst_w,
    parameter int INST_DEPTH = c_def_inst_depth,
    parameter int RES_W      = c_def_res_w,
    parameter int RES_DEPTH  = c_def_res_depth,
    parameter int AF_MARGIN  = c_def_af_margin
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush_inst,
    input  logic                           flush_result,
    input  logic                           wr_en_inst,
    input  logic                           rd_en_inst,
    input  logic [INST_W-1:0]              inst_in,
    output logic [INST_W-1:0]              inst_out,
    input  logic                           wr_en_result,
    input  logic                           rd_en_result,
    input  logic [RES_W-1:0]               result_in,
    output logic [RES_W-1:0]               result_out,
    output logic                           wr_ack_inst,
    output logic                           wr_err_inst,
    output logic                           rd_ack_inst,
    output logic                           rd_err_inst,
    output logic                           wr_ack_result,
    output logic                           wr_err_result,
    output logic                           rd_ack_result,
    output logic                           rd_err_result,
    output logic                           full_inst,
    output logic                           empty_inst,
    output logic                           almost_full_inst,
    output logic                           full_result,
    output logic                           empty_result,
    output logic                           almost_full_result,
    output logic [count_w(INST_DEPTH)-1:0] inst_count,
    output logic [count_w(RES_DEPTH)-1:0]  result_count
);

    fifo_core #(
        .W         (INST_W),
        .DEPTH     (INST_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_inst_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush_inst),
        .wr_en       (wr_en_inst),
        .rd_en       (rd_en_inst),
        .din         (inst_in),
        .dout        (inst_out),
        .wr_ack      (wr_ack_inst),
        .wr_err      (wr_err_inst),
        .rd_ack      (rd_ack_inst),
        .rd_err      (rd_err_inst),
        .full        (full_inst),
        .empty       (empty_inst),
        .almost_full (almost_full_inst),
        .count       (inst_count)
    );

    fifo_core #(
        .W         (RES_W),
        .DEPTH     (RES_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_result_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush_result),
        .wr_en       (wr_en_result),
        .rd_en       (rd_en_result),
        .din         (result_in),
        .dout        (result_out),
        .wr_ack      (wr_ack_result),
        .wr_err      (wr_err_result),
        .rd_ack      (rd_ack_result),
        .rd_err      (rd_err_result),
        .full        (full_result),
        .empty       (empty_result),
        .almost_full (almost_full_result),
        .count       (result_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_fifo_param
//  Brief    : Directed self-checking bench for the instruction/result FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_fifo_param;

    logic        clk;
    logic        reset_n;
    logic        flush_inst, flush_result;
    logic        wr_en_inst, rd_en_inst;
    logic [31:0] inst_in, inst_out;
    logic        wr_en_result, rd_en_result;
    logic [31:0] result_in, result_out;
    logic        wr_ack_inst, wr_err_inst, rd_ack_inst, rd_err_inst;
    logic        wr_ack_result, wr_err_result, rd_ack_result, rd_err_result;
    logic        full_inst, empty_inst, almost_full_inst;
    logic        full_result, empty_result, almost_full_result;
    logic [3:0]  inst_count;
    logic [4:0]  result_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_fifo_param dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .flush_inst         (flush_inst),
        .flush_result       (flush_result),
        .wr_en_inst         (wr_en_inst),
        .rd_en_inst         (rd_en_inst),
        .inst_in            (inst_in),
        .inst_out           (inst_out),
        .wr_en_result       (wr_en_result),
        .rd_en_result       (rd_en_result),
        .result_in          (result_in),
        .result_out         (result_out),
        .wr_ack_inst        (wr_ack_inst),
        .wr_err_inst        (wr_err_inst),
        .rd_ack_inst        (rd_ack_inst),
        .rd_err_inst        (rd_err_inst),
        .wr_ack_result      (wr_ack_result),
        .wr_err_result      (wr_err_result),
        .rd_ack_result      (rd_ack_result),
        .rd_err_result      (rd_err_result),
        .full_inst          (full_inst),
        .empty_inst         (empty_inst),
        .almost_full_inst   (almost_full_inst),
        .full_result        (full_result),
        .empty_result       (empty_result),
        .almost_full_result (almost_full_result),
        .inst_count         (inst_count),
        .result_count       (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change right after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        flush_inst   = 1'b0;
        flush_result = 1'b0;
        wr_en_inst   = 1'b0;
        rd_en_inst   = 1'b0;
        inst_in      = '0;
        wr_en_result = 1'b0;
        rd_en_result = 1'b0;
        result_in    = '0;
        tick();
        tick();

        check("rst_inst_out",    64'(inst_out), 64'h0);
        check("rst_result_out",  64'(result_out), 64'h0);
        check("rst_empty_inst",  64'(empty_inst), 64'h1);
        check("rst_empty_res",   64'(empty_result), 64'h1);
        check("rst_full_inst",   64'(full_inst), 64'h0);
        check("rst_af_inst",     64'(almost_full_inst), 64'h0);
        check("rst_af_res",      64'(almost_full_result), 64'h0);
        check("rst_inst_count",  64'(inst_count), 64'h0);
        check("rst_res_count",   64'(result_count), 64'h0);
        check("rst_wr_ack_inst", 64'(wr_ack_inst), 64'h0);
        reset_n = 1'b1;
        tick();

        // Fill the instruction FIFO with 1..8, then overflow once.
        wr_en_inst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inst_in = 32'(i);
            tick();
            check("fill_wr_ack", 64'(wr_ack_inst), 64'h1);
            check("fill_count",  64'(inst_count), 64'(i));
            check("fill_af",     64'(almost_full_inst), 64'(i >= 6));
        end
        inst_in = 32'h9;
        tick();
        check("ovf_wr_ack", 64'(wr_ack_inst), 64'h0);
        check("ovf_wr_err", 64'(wr_err_inst), 64'h1);
        check("ovf_full",   64'(full_inst), 64'h1);
        check("ovf_count",  64'(inst_count), 64'h8);
        wr_en_inst = 1'b0;

        // Drain in order, then underflow once.
        rd_en_inst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("drain_rd_ack", 64'(rd_ack_inst), 64'h1);
            check("drain_data",   64'(inst_out), 64'(i));
        end
        tick();
        check("udf_rd_err", 64'(rd_err_inst), 64'h1);
        check("udf_rd_ack", 64'(rd_ack_inst), 64'h0);
        check("udf_empty",  64'(empty_inst), 64'h1);
        check("udf_hold",   64'(inst_out), 64'h8);
        rd_en_inst = 1'b0;
        tick();
        check("err_pulse_width", 64'(rd_err_inst), 64'h0);

        // Simultaneous read and write on an empty FIFO: no pass-through.
        rd_en_inst = 1'b1;
        wr_en_inst = 1'b1;
        inst_in    = 32'h55;
        tick();
        check("e_rw_rd_err", 64'(rd_err_inst), 64'h1);
        check("e_rw_wr_ack", 64'(wr_ack_inst), 64'h1);
        check("e_rw_count",  64'(inst_count), 64'h1);
        check("e_rw_nopass", 64'(inst_out), 64'h8);
        wr_en_inst = 1'b0;
        tick();
        check("e_rw_read",  64'(inst_out), 64'h55);
        check("e_rw_rdack", 64'(rd_ack_inst), 64'h1);
        rd_en_inst = 1'b0;

        // Result FIFO full with simultaneous read and write.
        wr_en_result = 1'b1;
        for (int i = 0; i < 16; i++) begin
            result_in = 32'h100 + 32'(i);
            tick();
        end
        check("res_full_count", 64'(result_count), 64'h10);
        check("res_full",       64'(full_result), 64'h1);
        check("res_af",         64'(almost_full_result), 64'h1);
        rd_en_result = 1'b1;
        result_in    = 32'hAA;
        tick();
        check("f_rw_wr_ack", 64'(wr_ack_result), 64'h1);
        check("f_rw_rd_ack", 64'(rd_ack_result), 64'h1);
        check("f_rw_count",  64'(result_count), 64'h10);
        check("f_rw_data",   64'(result_out), 64'h100);
        wr_en_result = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("res_drain", 64'(result_out), (i < 16) ? 64'h100 + 64'(i) : 64'hAA);
        end
        check("res_empty", 64'(empty_result), 64'h1);
        rd_en_result = 1'b0;

        // Flush with a concurrent write; result channel must be untouched.
        wr_en_result = 1'b1;
        result_in    = 32'h33;
        tick();
        tick();
        wr_en_result = 1'b0;
        wr_en_inst   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst_in = 32'h10 + 32'(i);
            tick();
        end
        check("pre_flush_count", 64'(inst_count), 64'h5);
        flush_inst = 1'b1;
        inst_in    = 32'h99;
        tick();
        check("flush_count",  64'(inst_count), 64'h0);
        check("flush_wr_ack", 64'(wr_ack_inst), 64'h0);
        check("flush_wr_err", 64'(wr_err_inst), 64'h0);
        check("flush_empty",  64'(empty_inst), 64'h1);
        check("flush_dout",   64'(inst_out), 64'h55);
        check("flush_res",    64'(result_count), 64'h2);
        flush_inst = 1'b0;
        wr_en_inst = 1'b0;
        rd_en_inst = 1'b1;
        tick();
        check("post_flush_rd_err", 64'(rd_err_inst), 64'h1);
        rd_en_inst = 1'b0;

        // Asynchronous reset in the middle of a write burst.
        wr_en_inst = 1'b1;
        inst_in    = 32'h21;
        tick();
        inst_in = 32'h22;
        tick();
        check("burst_count", 64'(inst_count), 64'h2);
        reset_n = 1'b0;
        #1;
        check("arst_inst_count", 64'(inst_count), 64'h0);
        check("arst_res_count",  64'(result_count), 64'h0);
        check("arst_inst_out",   64'(inst_out), 64'h0);
        check("arst_res_out",    64'(result_out), 64'h0);
        check("arst_wr_ack",     64'(wr_ack_inst), 64'h0);
        check("arst_empty_inst", 64'(empty_inst), 64'h1);
        check("arst_empty_res",  64'(empty_result), 64'h1);
        tick();
        reset_n = 1'b1;
        inst_in = 32'h77;
        tick();
        check("rel_wr_ack", 64'(wr_ack_inst), 64'h1);
        check("rel_count",  64'(inst_count), 64'h1);
        wr_en_inst = 1'b0;
        rd_en_inst = 1'b1;
        tick();
        check("rel_read", 64'(inst_out), 64'h77);
        rd_en_inst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
